// File: rtl/bpred_pkg.sv
// Shared types and constants for the BTB-based next-PC predictor.
package bpred_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BLTZ = 3'd6
  } br_type_e;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  localparam logic [31:0] JMP_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
    return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer: two async read ports (fetch lookup and
// resolve-side update lookup), one sync write port, async clear.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] a_idx,
  output logic             a_valid,
  output logic [TAG_W-1:0] a_tag,
  output logic [XLEN-1:0]  a_target,
  output logic [1:0]       a_ctr,
  output logic             a_jump,
  input  logic [IDX_W-1:0] b_idx,
  output logic             b_valid,
  output logic [TAG_W-1:0] b_tag,
  output logic [XLEN-1:0]  b_target,
  output logic [1:0]       b_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr,
  input  logic             wr_jump
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][XLEN-1:0]  target_q, target_d;
  logic [DEPTH-1:0][1:0]       ctr_q, ctr_d;
  logic [DEPTH-1:0]            jump_q, jump_d;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jump_d   = jump_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
      ctr_d[wr_idx]    = wr_ctr;
      jump_d[wr_idx]   = wr_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {DEPTH{CTR_WEAK_NT}};
      jump_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      jump_q   <= jump_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not visible.
  assign a_valid  = valid_q[a_idx];
  assign a_tag    = tag_q[a_idx];
  assign a_target = target_q[a_idx];
  assign a_ctr    = ctr_q[a_idx];
  assign a_jump   = jump_q[a_idx];
  assign b_valid  = valid_q[b_idx];
  assign b_tag    = tag_q[b_idx];
  assign b_target = target_q[b_idx];
  assign b_ctr    = ctr_q[b_idx];

endmodule

// File: rtl/bpred_npc.sv
// Next-PC unit: BTB prediction at IF, branch/jump resolution at ID, redirect
// and BTB training, plus a count of redirects.
module bpred_npc
  import bpred_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] JMP_BASE  = XLEN'(JMP_BASE_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  input  logic [2:0]      br_type,
  input  logic            is_jmp,
  input  logic            is_jr,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] br_offset,
  input  logic [25:0]     instr_index,
  output logic            flush,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     mispred_cnt_q, mispred_cnt_d;

  logic             a_valid, a_jump, b_valid, a_hit, b_hit;
  logic [TAG_W-1:0] a_tag, b_tag;
  logic [XLEN-1:0]  a_target, b_target;
  logic [1:0]       a_ctr, b_ctr;
  logic             wr_en;
  logic [1:0]       wr_ctr;
  logic [XLEN-1:0]  wr_target;

  br_type_e        br;
  logic            cond, act_taken, redirect, train;
  logic [XLEN-1:0] act_target, id_pc_plus4, if_pc_plus4;

  bpred_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .a_idx    (if_pc_q[IDX_W+1:2]),
    .a_valid  (a_valid),
    .a_tag    (a_tag),
    .a_target (a_target),
    .a_ctr    (a_ctr),
    .a_jump   (a_jump),
    .b_idx    (id_pc[IDX_W+1:2]),
    .b_valid  (b_valid),
    .b_tag    (b_tag),
    .b_target (b_target),
    .b_ctr    (b_ctr),
    .wr_en    (wr_en),
    .wr_idx   (id_pc[IDX_W+1:2]),
    .wr_tag   (id_pc[XLEN-1:IDX_W+2]),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr),
    .wr_jump  (is_jmp)
  );

  assign br          = br_type_e'(br_type);
  assign if_pc_plus4 = if_pc_q + XLEN'(4);
  assign id_pc_plus4 = id_pc + XLEN'(4);
  assign a_hit       = a_valid && (a_tag == if_pc_q[XLEN-1:IDX_W+2]);
  assign b_hit       = b_valid && (b_tag == id_pc[XLEN-1:IDX_W+2]);

  always_comb begin
    cond = 1'b0;
    unique case (br)
      BR_BEQ:  cond = (rdata1 == rdata2);
      BR_BNE:  cond = (rdata1 != rdata2);
      BR_BGEZ: cond = !rdata1[XLEN-1];
      BR_BGTZ: cond = !rdata1[XLEN-1] && (rdata1 != '0);
      BR_BLEZ: cond = rdata1[XLEN-1] || (rdata1 == '0);
      BR_BLTZ: cond = rdata1[XLEN-1];
      default: cond = 1'b0;
    endcase

    act_taken  = is_jmp || is_jr || cond;
    act_target = id_pc_plus4;
    if (is_jmp)     act_target = {id_pc[XLEN-1:28], instr_index, 2'b00} + JMP_BASE;
    else if (is_jr) act_target = rdata1 + JMP_BASE;
    else if (cond)  act_target = id_pc + (br_offset << 2);

    redirect = id_valid && !stall && !rst &&
               ((act_taken != id_pred_taken) || (act_taken && (act_target != id_pred_target)));

    train     = id_valid && !stall && !rst && !is_jr && ((br != BR_NONE) || is_jmp);
    wr_en     = train && (b_hit || act_taken);
    wr_ctr    = b_hit ? ctr_next(b_ctr, act_taken) : CTR_WEAK_T;
    wr_target = act_taken ? act_target : b_target;

    if_pred_taken  = a_hit && (a_jump || a_ctr[1]);
    if_pred_target = a_hit ? a_target : if_pc_plus4;

    // Sequential fetch follows the predicted path only when the BTB votes taken;
    // a weak not-taken hit must still fall through.
    if_pc_d = if_pred_taken ? if_pred_target : if_pc_plus4;
    if (stall)         if_pc_d = if_pc_q;
    else if (redirect) if_pc_d = act_target;

    mispred_cnt_d = mispred_cnt_q + 32'(redirect);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc_q       <= RESET_PC;
      mispred_cnt_q <= '0;
    end else begin
      if_pc_q       <= if_pc_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign if_pc       = if_pc_q;
  assign flush       = redirect;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bpred_npc.sv
// Bench for bpred_npc: directed vector table for the corner sequences, then
// random traffic compared against a behavioural predictor model.
module tb_bpred_npc;
  import bpred_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, id_valid, id_pred_taken, is_jmp, is_jr;
  logic [31:0] id_pc, id_pred_target, rdata1, rdata2, br_offset;
  logic [2:0]  br_type;
  logic [25:0] instr_index;
  logic [31:0] if_pc, if_pred_target, mispred_cnt;
  logic        if_pred_taken, flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpred_npc dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .br_type(br_type), .is_jmp(is_jmp), .is_jr(is_jr),
    .rdata1(rdata1), .rdata2(rdata2), .br_offset(br_offset), .instr_index(instr_index),
    .flush(flush), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        stall, id_valid;
    logic [31:0] id_pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [2:0]  br;
    logic        jmp, jr;
    logic [31:0] r1, r2, off;
    logic [25:0] iidx;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_flush;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: one slot per BTB index.
  logic [31:0] m_pc, m_cnt;
  bit          m_valid[DEPTH];
  logic [25:0] m_tag[DEPTH];
  logic [31:0] m_tgt[DEPTH];
  int          m_ctr[DEPTH];
  bit          m_jump[DEPTH];

  function automatic vec_t mk(logic st, logic v, logic [31:0] pc, logic pt, logic [31:0] ptgt,
                              logic [2:0] br, logic jmp, logic jr, logic [31:0] r1, logic [31:0] r2,
                              logic [31:0] off, logic [25:0] iidx, logic [31:0] e_pc, logic e_pt,
                              logic [31:0] e_ptgt, logic e_flush, logic [31:0] e_cnt);
    vec_t r;
    r.stall = st; r.id_valid = v; r.id_pc = pc; r.pt = pt; r.ptgt = ptgt; r.br = br;
    r.jmp = jmp; r.jr = jr; r.r1 = r1; r.r2 = r2; r.off = off; r.iidx = iidx;
    r.e_pc = e_pc; r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_flush = e_flush; r.e_cnt = e_cnt;
    return r;
  endfunction

  function automatic vec_t idle(logic [31:0] e_pc, logic e_pt, logic [31:0] e_ptgt, logic [31:0] e_cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_pt, e_ptgt, 0, e_cnt);
  endfunction

  task automatic applyStimulus(input vec_t v);
    stall = v.stall; id_valid = v.id_valid; id_pc = v.id_pc;
    id_pred_taken = v.pt; id_pred_target = v.ptgt; br_type = v.br;
    is_jmp = v.jmp; is_jr = v.jr; rdata1 = v.r1; rdata2 = v.r2;
    br_offset = v.off; instr_index = v.iidx;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] e_pc, input logic e_pt,
                             input logic [31:0] e_ptgt, input logic e_flush, input logic [31:0] e_cnt);
    check32({tag, " if_pc"}, if_pc, e_pc);
    check1({tag, " if_pred_taken"}, if_pred_taken, e_pt);
    check32({tag, " if_pred_target"}, if_pred_target, e_ptgt);
    check1({tag, " flush"}, flush, e_flush);
    check32({tag, " mispred_cnt"}, mispred_cnt, e_cnt);
  endtask

  function automatic void model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] ptgt);
    int i = int'(pc[5:2]);
    bit hit = m_valid[i] && (m_tag[i] == pc[31:6]);
    pt   = hit && (m_jump[i] || m_ctr[i] >= 2);
    ptgt = hit ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_resolve(input vec_t v, output logic taken, output logic [31:0] tgt);
    int  s1 = int'(v.r1);
    bit  c;
    case (v.br)
      3'd1:    c = (v.r1 == v.r2);
      3'd2:    c = (v.r1 != v.r2);
      3'd3:    c = (s1 >= 0);
      3'd4:    c = (s1 > 0);
      3'd5:    c = (s1 <= 0);
      3'd6:    c = (s1 < 0);
      default: c = 0;
    endcase
    taken = v.jmp || v.jr || c;
    if (v.jmp)     tgt = {v.id_pc[31:28], v.iidx, 2'b00} + 32'h3000;
    else if (v.jr) tgt = v.r1 + 32'h3000;
    else if (c)    tgt = v.id_pc + v.off * 32'd4;
    else           tgt = v.id_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_jump[i] = 0;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'd5;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_cycle(input int n);
    vec_t        v;
    logic        pt, taken, redir, idp;
    logic [31:0] ptgt, tgt, idt;
    int          kind, i;
    bit          hit;
    v = idle(0, 0, 0, 0);
    kind = $urandom_range(0, 9);
    v.stall = ($urandom_range(0, 7) == 0);
    v.id_valid = (kind != 9);
    v.id_pc = 32'h3000 + 32'd4 * $urandom_range(0, 63);
    if (kind <= 5) v.br = 3'($urandom_range(1, 6));
    v.jmp = (kind == 6);
    v.jr  = (kind == 7);
    v.r1 = pick_operand();
    v.r2 = $urandom_range(0, 1) ? v.r1 : pick_operand();
    v.off = 32'($urandom_range(0, 15)) - 32'd8;
    v.iidx = 26'($urandom_range(0, 63));
    model_resolve(v, taken, tgt);
    if ($urandom_range(0, 1)) begin
      model_lookup(v.id_pc, idp, idt);
      v.pt = idp; v.ptgt = idt;
    end else begin
      v.pt = 1'($urandom_range(0, 1));
      v.ptgt = $urandom_range(0, 1) ? tgt : 32'h3000 + 32'd4 * $urandom_range(0, 63);
    end
    applyStimulus(v);
    #1;
    model_lookup(m_pc, pt, ptgt);
    redir = v.id_valid && !v.stall && ((taken != v.pt) || (taken && tgt != v.ptgt));
    checkOutput($sformatf("rand%0d", n), m_pc, pt, ptgt, redir, m_cnt);
    if (v.stall)    m_pc = m_pc;
    else if (redir) m_pc = tgt;
    else            m_pc = pt ? ptgt : m_pc + 32'd4;
    if (redir) m_cnt = m_cnt + 1;
    if (v.id_valid && !v.stall && !v.jr && (v.br != 0 || v.jmp)) begin
      i = int'(v.id_pc[5:2]);
      hit = m_valid[i] && (m_tag[i] == v.id_pc[31:6]);
      if (hit) begin
        m_ctr[i] = taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (taken) m_tgt[i] = tgt;
        m_jump[i] = v.jmp;
      end else if (taken) begin
        m_valid[i] = 1; m_tag[i] = v.id_pc[31:6]; m_tgt[i] = tgt; m_ctr[i] = 2; m_jump[i] = v.jmp;
      end
    end
  endtask

  initial begin
    // Reset release, BEQ training, stall hold, jr, aliasing eviction.
    vecs.push_back(idle(32'h3000, 0, 32'h3004, 0));
    vecs.push_back(idle(32'h3004, 0, 32'h3008, 0));
    vecs.push_back(idle(32'h3008, 0, 32'h300C, 0));
    vecs.push_back(mk(0, 1, 32'h3010, 0, 32'h3014, 3'd1, 0, 0, 5, 5, 4, 0, 32'h300C, 0, 32'h3010, 1, 0));
    vecs.push_back(idle(32'h3020, 0, 32'h3024, 1));
    vecs.push_back(mk(0, 1, 32'h3024, 0, 32'h3028, 3'd0, 1, 0, 0, 0, 0, 4, 32'h3024, 0, 32'h3028, 1, 1));
    vecs.push_back(idle(32'h3010, 1, 32'h3020, 2));
    vecs.push_back(mk(0, 1, 32'h3010, 1, 32'h3020, 3'd1, 0, 0, 7, 7, 4, 0, 32'h3020, 0, 32'h3024, 0, 2));
    vecs.push_back(idle(32'h3024, 1, 32'h3010, 2));
    vecs.push_back(mk(1, 1, 32'h3010, 1, 32'h3020, 3'd1, 0, 0, 1, 2, 4, 0, 32'h3010, 1, 32'h3020, 0, 2));
    vecs.push_back(mk(0, 1, 32'h3010, 1, 32'h3020, 3'd1, 0, 0, 1, 2, 4, 0, 32'h3010, 1, 32'h3020, 1, 2));
    vecs.push_back(idle(32'h3014, 0, 32'h3018, 3));
    vecs.push_back(mk(0, 1, 32'h3040, 0, 32'h3044, 3'd0, 1, 0, 0, 0, 0, 4, 32'h3018, 0, 32'h301C, 1, 3));
    vecs.push_back(idle(32'h3010, 1, 32'h3020, 4));
    vecs.push_back(mk(0, 1, 32'h3020, 0, 32'h3024, 3'd0, 0, 1, 32'h100, 0, 0, 0, 32'h3020, 0, 32'h3024, 1, 4));
    vecs.push_back(idle(32'h3100, 0, 32'h3104, 5));
    vecs.push_back(mk(0, 1, 32'h3004, 0, 32'h3008, 3'd0, 1, 0, 0, 0, 0, 8, 32'h3104, 0, 32'h3108, 1, 5));
    vecs.push_back(idle(32'h3020, 0, 32'h3024, 6));
    vecs.push_back(mk(0, 1, 32'h3050, 0, 32'h3054, 3'd1, 0, 0, 0, 0, 4, 0, 32'h3024, 1, 32'h3010, 1, 6));
    vecs.push_back(mk(0, 1, 32'h3000, 0, 32'h3004, 3'd0, 1, 0, 0, 0, 0, 4, 32'h3060, 0, 32'h3064, 1, 7));
    vecs.push_back(idle(32'h3010, 0, 32'h3014, 8));

    rst = 1'b1;
    applyStimulus(mk(0, 1, 32'h3000, 0, 32'h3004, 3'd0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
    #12;
    checkOutput("in_reset", 32'h3000, 0, 32'h3004, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_pt, vecs[k].e_ptgt,
                  vecs[k].e_flush, vecs[k].e_cnt);
      @(negedge clk);
    end

    // Reset landing on a pending redirect; BTB must come back empty.
    applyStimulus(mk(0, 1, 32'h3000, 0, 32'h3004, 3'd0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    checkOutput("midrst", 32'h3000, 0, 32'h3004, 0, 0);
    @(posedge clk);
    #1;
    check32("midrst_hold if_pc", if_pc, 32'h3000);
    @(negedge clk);
    applyStimulus(idle(0, 0, 0, 0));
    rst = 1'b0;
    #1;
    checkOutput("post_rst", 32'h3000, 0, 32'h3004, 0, 0);

    model_reset();
    m_pc = 32'h3004;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      random_cycle(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
